// File: rtl/gate_selftest_checker_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// gate_selftest_checker_if
// Bundles the stimulus, observed gate outputs and result signals of the
// gate self-test checker.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
interface gate_selftest_checker_if #(
  parameter int ERR_W = 3
);
  logic             start;
  logic             a_out;
  logic             b_out;
  logic             and_in;
  logic             or_in;
  logic             nand_in;
  logic             nor_in;
  logic             notb_in;
  logic             xor_in;
  logic             xnor_in;
  logic             busy;
  logic             done;
  logic             pass;
  logic [ERR_W-1:0] err_count;
  logic [6:0]       fail_vec;

  // Environment side: issues start and returns the gate block outputs.
  modport master (
    output start,
    input  a_out, b_out,
    output and_in, or_in, nand_in, nor_in, notb_in, xor_in, xnor_in,
    input  busy, done, pass, err_count, fail_vec
  );

  // Checker side.
  modport slave (
    input  start,
    output a_out, b_out,
    input  and_in, or_in, nand_in, nor_in, notb_in, xor_in, xnor_in,
    output busy, done, pass, err_count, fail_vec
  );
endinterface
`default_nettype wire

// File: rtl/gate_selftest_checker.sv
`default_nettype none
// ---------------------------------------------------------------------------
// gate_selftest_checker
// Built-in self-test for the two-input gate block: steps a,b through all four
// combinations, lets each settle, and compares the seven gate outputs with
// the truth table. Reports pass/fail, a saturating error count and a sticky
// per-gate failure mask.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
module gate_selftest_checker #(
  parameter int SETTLE_CYCLES = 2,
  parameter int ERR_W         = 3
) (
  input  wire                     clk,
  input  wire                     rst_n,
  gate_selftest_checker_if.slave  bus
);

  localparam int CNT_W = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);
  localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_CHECK  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       vec_q, vec_d;
  logic             a_q, a_d;
  logic             b_q, b_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic [6:0]       fail_q, fail_d;
  logic             pass_q, pass_d;

  logic [6:0]       exp_vec;
  logic [6:0]       obs_vec;
  logic [6:0]       mism;

  // Truth table for the vector currently driven, and the observed outputs.
  assign exp_vec = {~(a_q ^ b_q), a_q ^ b_q, ~b_q, ~(a_q | b_q),
                    ~(a_q & b_q), a_q | b_q, a_q & b_q};
  assign obs_vec = {bus.xnor_in, bus.xor_in, bus.notb_in, bus.nor_in,
                    bus.nand_in, bus.or_in, bus.and_in};
  assign mism    = exp_vec ^ obs_vec;

  // State and datapath registers; reset abandons any run in progress.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      vec_q   <= 2'd0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      cnt_q   <= '0;
      err_q   <= '0;
      fail_q  <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      fail_q  <= fail_d;
      pass_q  <= pass_d;
    end
  end

  // Sequencer: start -> (settle, check) x 4 -> done pulse -> idle.
  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    fail_d  = fail_q;
    pass_d  = pass_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          err_d   = '0;
          fail_d  = '0;
          pass_d  = 1'b0;
          vec_d   = 2'd0;
          a_d     = 1'b0;
          b_d     = 1'b0;
          cnt_d   = CNT_LOAD;
          state_d = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (cnt_q == CNT_LAST) begin
          state_d = S_CHECK;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_CHECK: begin
        fail_d = fail_q | mism;
        if ((mism != 7'd0) && (err_q != ERR_MAX)) begin
          err_d = err_q + ERR_W'(1);
        end
        if (vec_q != 2'd3) begin
          vec_d      = vec_q + 2'd1;
          {a_d, b_d} = vec_q + 2'd1;
          cnt_d      = CNT_LOAD;
          state_d    = S_SETTLE;
        end else begin
          // Resolve pass here so it is already valid alongside done.
          pass_d  = ((fail_q | mism) == 7'd0);
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.a_out     = a_q;
  assign bus.b_out     = b_q;
  assign bus.busy      = (state_q == S_SETTLE) || (state_q == S_CHECK);
  assign bus.done      = (state_q == S_DONE);
  assign bus.pass      = pass_q;
  assign bus.err_count = err_q;
  assign bus.fail_vec  = fail_q;

endmodule
`default_nettype wire

// File: tb/tb_gate_selftest_checker.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_gate_selftest_checker
// Directed bench: a behavioural gate block with selectable faults feeds the
// checker; results, stimulus sequence and latency are compared against
// hand-derived values.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_gate_selftest_checker;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   fault_mode;
  int   lat;
  int   dones;

  always #5 clk = ~clk;

  gate_selftest_checker_if #(.ERR_W(3)) bus0 ();
  gate_selftest_checker_if #(.ERR_W(2)) bus1 ();

  gate_selftest_checker #(.SETTLE_CYCLES(2), .ERR_W(3)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0.slave)
  );

  gate_selftest_checker #(.SETTLE_CYCLES(2), .ERR_W(2)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1.slave)
  );

  // Gate block model for dut0: 0 good, 1 and stuck 0, 2 notb=b, 3 all inverted.
  always_comb begin
    bus0.and_in  = bus0.a_out & bus0.b_out;
    bus0.or_in   = bus0.a_out | bus0.b_out;
    bus0.nand_in = ~(bus0.a_out & bus0.b_out);
    bus0.nor_in  = ~(bus0.a_out | bus0.b_out);
    bus0.notb_in = ~bus0.b_out;
    bus0.xor_in  = bus0.a_out ^ bus0.b_out;
    bus0.xnor_in = ~(bus0.a_out ^ bus0.b_out);
    case (fault_mode)
      1: bus0.and_in = 1'b0;
      2: bus0.notb_in = bus0.b_out;
      3: begin
        bus0.and_in  = ~(bus0.a_out & bus0.b_out);
        bus0.or_in   = ~(bus0.a_out | bus0.b_out);
        bus0.nand_in = bus0.a_out & bus0.b_out;
        bus0.nor_in  = bus0.a_out | bus0.b_out;
        bus0.notb_in = bus0.b_out;
        bus0.xor_in  = ~(bus0.a_out ^ bus0.b_out);
        bus0.xnor_in = bus0.a_out ^ bus0.b_out;
      end
      default: ;
    endcase
  end

  // dut1 always sees every gate output inverted.
  assign bus1.and_in  = ~(bus1.a_out & bus1.b_out);
  assign bus1.or_in   = ~(bus1.a_out | bus1.b_out);
  assign bus1.nand_in = bus1.a_out & bus1.b_out;
  assign bus1.nor_in  = bus1.a_out | bus1.b_out;
  assign bus1.notb_in = bus1.b_out;
  assign bus1.xor_in  = ~(bus1.a_out ^ bus1.b_out);
  assign bus1.xnor_in = bus1.a_out ^ bus1.b_out;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Returns at the negedge of the first cycle after start was sampled.
  task automatic start_pulse(input bit sel);
    @(negedge clk);
    if (sel) bus1.start = 1'b1; else bus0.start = 1'b1;
    @(negedge clk);
    bus0.start = 1'b0;
    bus1.start = 1'b0;
  endtask

  // n0 is the cycle number (relative to the start edge) of the current negedge.
  task automatic wait_done(input bit sel, input int n0, output int n);
    n = n0;
    while (!(sel ? bus1.done : bus0.done) && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic count_dones(input int cycles, output int cnt);
    cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (bus0.done) cnt++;
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    bus0.start = 1'b0;
    bus1.start = 1'b0;
    fault_mode = 0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_ab",   {30'd0, bus0.a_out, bus0.b_out}, 32'd0);
    check("rst_busy", {31'd0, bus0.busy}, 32'd0);
    check("rst_done", {31'd0, bus0.done}, 32'd0);
    check("rst_pass", {31'd0, bus0.pass}, 32'd0);
    check("rst_err",  {29'd0, bus0.err_count}, 32'd0);
    check("rst_fail", {25'd0, bus0.fail_vec}, 32'd0);
    rst_n = 1'b1;

    // 1: good gate block, stimulus sequence and latency
    fault_mode = 0;
    start_pulse(1'b0);
    for (int n = 1; n <= 12; n++) begin
      check($sformatf("t1_ab_c%0d", n), {30'd0, bus0.a_out, bus0.b_out}, (n - 1) / 3);
      check($sformatf("t1_busy_c%0d", n), {31'd0, bus0.busy}, 32'd1);
      check($sformatf("t1_done_c%0d", n), {31'd0, bus0.done}, 32'd0);
      @(negedge clk);
    end
    check("t1_done",  {31'd0, bus0.done}, 32'd1);
    check("t1_busy",  {31'd0, bus0.busy}, 32'd0);
    check("t1_pass",  {31'd0, bus0.pass}, 32'd1);
    check("t1_err",   {29'd0, bus0.err_count}, 32'd0);
    check("t1_fail",  {25'd0, bus0.fail_vec}, 32'd0);
    @(negedge clk);
    check("t1_done_low", {31'd0, bus0.done}, 32'd0);
    check("t1_ab_hold",  {30'd0, bus0.a_out, bus0.b_out}, 32'd3);
    check("t1_pass_hold", {31'd0, bus0.pass}, 32'd1);

    // 2: and stuck at 0 -> only vector 11 fails
    fault_mode = 1;
    start_pulse(1'b0);
    wait_done(1'b0, 1, lat);
    check("t2_lat",  lat, 32'd13);
    check("t2_err",  {29'd0, bus0.err_count}, 32'd1);
    check("t2_fail", {25'd0, bus0.fail_vec}, 32'h01);
    check("t2_pass", {31'd0, bus0.pass}, 32'd0);

    // 3: notb follows b -> every vector fails
    fault_mode = 2;
    start_pulse(1'b0);
    wait_done(1'b0, 1, lat);
    check("t3_lat",  lat, 32'd13);
    check("t3_err",  {29'd0, bus0.err_count}, 32'd4);
    check("t3_fail", {25'd0, bus0.fail_vec}, 32'h10);
    check("t3_pass", {31'd0, bus0.pass}, 32'd0);

    // 4: ERR_W=2, all inverted -> counter saturates at 3
    start_pulse(1'b1);
    wait_done(1'b1, 1, lat);
    check("t4_lat",  lat, 32'd13);
    check("t4_err",  {30'd0, bus1.err_count}, 32'd3);
    check("t4_fail", {25'd0, bus1.fail_vec}, 32'h7F);
    check("t4_pass", {31'd0, bus1.pass}, 32'd0);

    // 5: start during SETTLE of vec 1 is ignored
    fault_mode = 0;
    start_pulse(1'b0);
    repeat (3) @(negedge clk);
    check("t5_ab_vec1", {30'd0, bus0.a_out, bus0.b_out}, 32'd1);
    bus0.start = 1'b1;
    @(negedge clk);
    bus0.start = 1'b0;
    wait_done(1'b0, 5, lat);
    check("t5_lat",  lat, 32'd13);
    check("t5_pass", {31'd0, bus0.pass}, 32'd1);
    count_dones(20, dones);
    check("t5_extra_done", dones, 32'd0);

    // 6: reset during CHECK of vec 2 abandons the run
    fault_mode = 3;
    start_pulse(1'b0);
    repeat (8) @(negedge clk);
    check("t6_err_live",  {29'd0, bus0.err_count}, 32'd2);
    check("t6_fail_live", {25'd0, bus0.fail_vec}, 32'h7F);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("t6_ab",   {30'd0, bus0.a_out, bus0.b_out}, 32'd0);
    check("t6_busy", {31'd0, bus0.busy}, 32'd0);
    check("t6_done", {31'd0, bus0.done}, 32'd0);
    check("t6_pass", {31'd0, bus0.pass}, 32'd0);
    check("t6_err",  {29'd0, bus0.err_count}, 32'd0);
    check("t6_fail", {25'd0, bus0.fail_vec}, 32'd0);
    count_dones(20, dones);
    check("t6_no_done", dones, 32'd0);
    fault_mode = 0;
    start_pulse(1'b0);
    wait_done(1'b0, 1, lat);
    check("t6_rerun_lat",  lat, 32'd13);
    check("t6_rerun_pass", {31'd0, bus0.pass}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
